// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults, output-action encoding and helpers for the decode-stage load-use hazard unit.
package hdu_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 3;
  localparam int unsigned LOAD_LAT_DEF   = 1;

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_FREEZE = 2'd1,
    ACT_BUBBLE = 2'd2
  } hdu_act_e;

  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

  // Extract source index i of width w from a zero-extended packed source vector.
  function automatic int unsigned src_idx(input logic [63:0] packed_src,
                                          input int unsigned i,
                                          input int unsigned w);
    logic [63:0] shifted;
    shifted = (packed_src >> (i * w)) & ((64'd1 << w) - 64'd1);
    return 32'(shifted);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_timer.sv
// Per-register countdown of cycles until an in-flight load result becomes usable.
module hdu_reg_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  // A load arriving while the count is still running restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (load)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: per-register load timers, source/destination compare, pipeline enables, stall counter.
module hazard_scoreboard
  import hdu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned LOAD_LAT      = LOAD_LAT_DEF,
  parameter int unsigned ZERO_REG_HARD = 0,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] SRC_F_D,
  input  logic [NUM_SRC-1:0]            SRC_VLD,
  input  logic [REG_ADDR_W-1:0]         DST_F_D,
  input  logic                          DST_CHK,
  input  logic [REG_ADDR_W-1:0]         DST_D_E,
  input  logic                          MEM_READ,
  input  logic                          D_E_VLD,
  input  logic                          HAZARD_POP,
  input  logic                          FLUSH_BR,
  input  logic                          MEM_WAIT,
  output logic                          F_D_ENB,
  output logic                          PC_ENB,
  output logic                          FLUSH_LOAD_USE,
  output logic [2**REG_ADDR_W-1:0]      BUSY_MASK,
  output logic [STALL_CNT_W-1:0]        STALL_CNT
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W    = cnt_width(LOAD_LAT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT - 1);

  logic                ld_live;
  logic [NUM_REGS-1:0] pend;
  logic                hit;
  logic                luse;
  hdu_act_e            act;

  assign ld_live = MEM_READ & D_E_VLD;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_timer
    localparam bit HARD0 = (ZERO_REG_HARD != 0) && (r == 0);
    hdu_reg_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (CLK),
      .rst_n    (RST_N),
      .freeze   (MEM_WAIT),
      .load     (ld_live && (DST_D_E == REG_ADDR_W'(r)) && !HARD0),
      .load_val (LOAD_VAL),
      .busy     (BUSY_MASK[r])
    );
  end

  always_comb begin
    pend = BUSY_MASK;
    if (ld_live)
      pend[DST_D_E] = 1'b1;
    if (ZERO_REG_HARD != 0)
      pend[0] = 1'b0;
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SRC_VLD[i] && pend[REG_ADDR_W'(src_idx(64'(SRC_F_D), i, REG_ADDR_W))])
        hit = 1'b1;
    end
    if (DST_CHK && pend[DST_F_D])
      hit = 1'b1;
  end

  assign luse = HAZARD_POP & ~FLUSH_BR & ~MEM_WAIT & hit;

  // Reset forces the pipeline to run regardless of the live D/E term.
  always_comb begin
    act = ACT_RUN;
    if (!RST_N)
      act = ACT_RUN;
    else if (MEM_WAIT)
      act = ACT_FREEZE;
    else if (luse)
      act = ACT_BUBBLE;
  end

  assign F_D_ENB        = (act == ACT_RUN);
  assign PC_ENB         = (act == ACT_RUN);
  assign FLUSH_LOAD_USE = (act == ACT_BUBBLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      STALL_CNT <= '0;
    else if (luse && (STALL_CNT != '1))
      STALL_CNT <= STALL_CNT + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three parameterisations share one stimulus stream against a ready-time model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] src;
  logic [1:0] vld;
  logic [2:0] dst;
  logic       dchk;
  logic [2:0] dde;
  logic       mr, dev, hp, fb, mw;

  logic       fd [3];
  logic       pc [3];
  logic       fl [3];
  logic [7:0] bm [3];
  logic [3:0]  sc0;
  logic [15:0] sc1, sc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // inst 0: LOAD_LAT=3, r0 hard-wired, 4-bit counter
  hazard_scoreboard #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(3), .ZERO_REG_HARD(1), .STALL_CNT_W(4)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .SRC_F_D(src), .SRC_VLD(vld), .DST_F_D(dst), .DST_CHK(dchk),
    .DST_D_E(dde), .MEM_READ(mr), .D_E_VLD(dev), .HAZARD_POP(hp), .FLUSH_BR(fb), .MEM_WAIT(mw),
    .F_D_ENB(fd[0]), .PC_ENB(pc[0]), .FLUSH_LOAD_USE(fl[0]), .BUSY_MASK(bm[0]), .STALL_CNT(sc0));

  hazard_scoreboard #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(1), .ZERO_REG_HARD(0), .STALL_CNT_W(16)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .SRC_F_D(src), .SRC_VLD(vld), .DST_F_D(dst), .DST_CHK(dchk),
    .DST_D_E(dde), .MEM_READ(mr), .D_E_VLD(dev), .HAZARD_POP(hp), .FLUSH_BR(fb), .MEM_WAIT(mw),
    .F_D_ENB(fd[1]), .PC_ENB(pc[1]), .FLUSH_LOAD_USE(fl[1]), .BUSY_MASK(bm[1]), .STALL_CNT(sc1));

  hazard_scoreboard #(.REG_ADDR_W(3), .NUM_SRC(2), .LOAD_LAT(2), .ZERO_REG_HARD(0), .STALL_CNT_W(16)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .SRC_F_D(src), .SRC_VLD(vld), .DST_F_D(dst), .DST_CHK(dchk),
    .DST_D_E(dde), .MEM_READ(mr), .D_E_VLD(dev), .HAZARD_POP(hp), .FLUSH_BR(fb), .MEM_WAIT(mw),
    .F_D_ENB(fd[2]), .PC_ENB(pc[2]), .FLUSH_LOAD_USE(fl[2]), .BUSY_MASK(bm[2]), .STALL_CNT(sc2));

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : 2;
  endfunction

  function automatic bit zh_of(input int k);
    return (k == 0);
  endfunction

  function automatic int maxc_of(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  function automatic int sc_of(input int k);
    return (k == 0) ? int'(sc0) : (k == 1) ? int'(sc1) : int'(sc2);
  endfunction

  // Model: a load leaving D/E after MEM_WAIT-free cycle e keeps its register unusable until cycle e+LAT-1.
  int t;
  int ready_t [3][8];
  int scnt [3];

  function automatic bit m_busy(input int k, input int r);
    return t < ready_t[k][r];
  endfunction

  function automatic bit m_pend(input int k, input int r);
    if (zh_of(k) && r == 0) return 1'b0;
    return (mr && dev && int'(dde) == r) || m_busy(k, r);
  endfunction

  function automatic bit m_luse(input int k);
    bit any;
    any = (vld[0] && m_pend(k, int'(src[2:0]))) || (vld[1] && m_pend(k, int'(src[5:3])))
          || (dchk && m_pend(k, int'(dst)));
    return hp && !fb && !mw && any;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0;
      for (int k = 0; k < 3; k++) begin
        scnt[k] <= 0;
        for (int r = 0; r < 8; r++) ready_t[k][r] <= 0;
      end
    end else if (!mw) begin
      t <= t + 1;
      for (int k = 0; k < 3; k++) begin
        if (m_luse(k) && scnt[k] < maxc_of(k)) scnt[k] <= scnt[k] + 1;
        if (mr && dev && !(zh_of(k) && dde == 3'd0)) ready_t[k][dde] <= t + lat_of(k);
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 3; k++) begin
      bit lu;
      int m;
      lu = m_luse(k);
      m = 0;
      for (int r = 0; r < 8; r++) if (m_busy(k, r)) m |= (1 << r);
      chk($sformatf("fd_enb[%0d]", k), fd[k], !(mw || lu));
      chk($sformatf("pc_enb[%0d]", k), pc[k], !(mw || lu));
      chk($sformatf("flush[%0d]", k), fl[k], !mw && lu);
      chk($sformatf("busy_mask[%0d]", k), bm[k], m);
      chk($sformatf("stall_cnt[%0d]", k), sc_of(k), scnt[k]);
    end
  endtask

  task automatic set_in(input logic [5:0] s, input logic [1:0] v, input logic [2:0] d, input logic dc,
                        input logic [2:0] de, input logic m, input logic dv, input logic h,
                        input logic f, input logic w);
    src = s; vld = v; dst = d; dchk = dc; dde = de; mr = m; dev = dv; hp = h; fb = f; mw = w;
  endtask

  task automatic idle();
    set_in(6'd0, 2'b00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] s; logic [1:0] v; logic [2:0] d; logic dc; logic [2:0] de;
    logic m, dv, h, f, w;
    logic exp_stall, exp_flush;
  } vec_t;

  vec_t vecs [12];
  int stalls [3];
  int b5;

  initial begin
    vecs[0]  = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'o03, 2'b00, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{6'o00, 2'b01, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'o30, 2'b10, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{6'o00, 2'b00, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{6'o00, 2'b00, 3'd3, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{6'o12, 2'b11, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    idle();
    rst_n = 1'b0;
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_fd[%0d]", k), fd[k], 1);
      chk($sformatf("rst_pc[%0d]", k), pc[k], 1);
      chk($sformatf("rst_flush[%0d]", k), fl[k], 0);
      chk($sformatf("rst_busy[%0d]", k), bm[k], 0);
      chk($sformatf("rst_sc[%0d]", k), sc_of(k), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle vectors from a clean state.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pulse_reset();
      set_in(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].dc, vecs[i].de, vecs[i].m, vecs[i].dv,
             vecs[i].h, vecs[i].f, vecs[i].w);
      #1;
      chk($sformatf("vec%0d_fd", i), fd[0], !vecs[i].exp_stall);
      chk($sformatf("vec%0d_pc", i), pc[0], !vecs[i].exp_stall);
      chk($sformatf("vec%0d_flush", i), fl[0], vecs[i].exp_flush);
      chk_all();
    end

    // Load r5, dependent directly behind: stall length equals LOAD_LAT.
    @(negedge clk);
    pulse_reset();
    set_in(6'o05, 2'b01, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) stalls[k] = 0;
    b5 = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) dev = 1'b0;
      #1;
      chk_all();
      for (int k = 0; k < 3; k++) if (!fd[k]) stalls[k]++;
      if (bm[0] == 8'h20) b5++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_len[%0d]", k), stalls[k], lat_of(k));
      chk($sformatf("stall_cnt_seq[%0d]", k), sc_of(k), lat_of(k));
    end
    chk("busy_r5_cycles", b5, 2);

    // Load r2 then a 4-cycle memory wait: timers freeze, no bubble, remainder completes.
    pulse_reset();
    set_in(6'o02, 2'b01, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mw_first_stall", fd[0], 0);
    chk_all();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      dev = 1'b0;
      mw = 1'b1;
      #1;
      chk("mw_flush", fl[0], 0);
      chk("mw_busy_frozen", bm[0], 8'h04);
      chk_all();
      @(negedge clk);
    end
    mw = 1'b0;
    stalls[0] = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_all();
      if (!fd[0]) stalls[0]++;
      @(negedge clk);
    end
    chk("mw_remaining_stalls", stalls[0], 2);
    chk("mw_stall_cnt", sc0, 3);

    // Back-to-back loads to r4 with LOAD_LAT=2: the second load restarts the timer.
    pulse_reset();
    set_in(6'o00, 2'b00, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("b2b_c0", bm[2], 8'h00);
    @(negedge clk);
    #1;
    chk("b2b_c1", bm[2], 8'h10);
    chk_all();
    @(negedge clk);
    dev = 1'b0;
    #1;
    chk("b2b_c2_reload", bm[2], 8'h10);
    chk_all();
    @(negedge clk);
    #1;
    chk("b2b_c3", bm[2], 8'h00);
    chk_all();

    // Continuous stall for 20 cycles saturates the 4-bit counter.
    @(negedge clk);
    pulse_reset();
    set_in(6'o01, 2'b01, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk_all();
      @(negedge clk);
    end
    chk("sat_cnt4", sc0, 15);
    chk("sat_cnt16", sc1, 20);

    // Asynchronous reset with loads pending.
    pulse_reset();
    set_in(6'o00, 2'b00, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    dde = 3'd4;
    @(negedge clk);
    idle();
    #1;
    chk("pre_rst_busy", bm[0], 8'h18);
    set_in(6'o03, 2'b01, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bm[0], 0);
    chk("arst_sc", sc0, 0);
    chk("arst_fd", fd[0], 1);
    chk("arst_pc", pc[0], 1);
    chk("arst_flush", fl[0], 0);
    idle();
    rst_n = 1'b1;
    #1;
    chk_all();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) pulse_reset();
      src  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      vld  = 2'($urandom);
      dst  = 3'($urandom_range(0, 3));
      dchk = ($urandom_range(0, 3) == 0);
      dde  = 3'($urandom_range(0, 3));
      mr   = 1'($urandom);
      dev  = ($urandom_range(0, 3) != 0);
      hp   = ($urandom_range(0, 7) != 0);
      fb   = ($urandom_range(0, 7) == 0);
      mw   = ($urandom_range(0, 7) == 0);
      #1;
      chk_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
